// File: rtl/csum_accumulator.sv
// Streaming RFC 1071 one's-complement checksum over 32-bit big-endian beats.
// Accumulates hi/lo halves plus a pseudo-header seed, folds twice and emits ~sum.
module csum_accumulator #(
  parameter int unsigned WIDTH    = 32,
  parameter bit          UDP_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_first,
  input  logic             in_last,
  input  logic [2:0]       in_bytes,
  input  logic [15:0]      seed,
  output logic [15:0]      csum,
  output logic             csum_valid,
  input  logic             csum_ready,
  output logic [15:0]      byte_count,
  output logic             err
);

  typedef enum logic [2:0] {StIdle, StAccum, StFold1, StFold2, StDone} state_e;

  state_e      state_q;
  logic [31:0] acc_q;
  logic [15:0] csum_q;
  logic        csum_valid_q;
  logic [15:0] byte_count_q;
  logic        err_q;

  logic        accept;
  logic [2:0]  last_bytes;
  logic [31:0] masked_data;
  logic [31:0] beat_sum;
  logic [15:0] beat_bytes;
  logic [31:0] fold;
  logic [15:0] final_csum;

  assign in_ready = (state_q == StIdle) || (state_q == StAccum);
  assign accept   = in_valid && in_ready;

  always_comb begin
    last_bytes  = 3'd4;
    masked_data = in_data[31:0];
    if (in_last) begin
      if (in_bytes != 3'd0 && in_bytes < 3'd4) last_bytes = in_bytes;
      // Bytes past the packet end are zero so an odd tail pads with 0x00.
      unique case (last_bytes)
        3'd1:    masked_data = {in_data[31:24], 24'h0};
        3'd2:    masked_data = {in_data[31:16], 16'h0};
        3'd3:    masked_data = {in_data[31:8], 8'h0};
        default: masked_data = in_data[31:0];
      endcase
    end
    beat_sum   = {16'h0, masked_data[31:16]} + {16'h0, masked_data[15:0]};
    beat_bytes = {13'h0, last_bytes};
    fold       = {16'h0, acc_q[15:0]} + {16'h0, acc_q[31:16]};
    final_csum = ~fold[15:0];
    if (UDP_ZERO && final_csum == 16'h0000) final_csum = 16'hFFFF;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      acc_q        <= '0;
      csum_q       <= '0;
      csum_valid_q <= 1'b0;
      byte_count_q <= '0;
      err_q        <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (in_first) begin
              acc_q        <= {16'h0, seed} + beat_sum;
              byte_count_q <= beat_bytes;
              state_q      <= in_last ? StFold1 : StAccum;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StAccum: begin
          if (accept) begin
            if (in_first) begin
              // A fresh first beat abandons the open packet and starts over.
              acc_q        <= {16'h0, seed} + beat_sum;
              byte_count_q <= beat_bytes;
              err_q        <= 1'b1;
            end else begin
              acc_q        <= acc_q + beat_sum;
              byte_count_q <= byte_count_q + beat_bytes;
            end
            if (in_last) state_q <= StFold1;
          end
        end
        StFold1: begin
          acc_q   <= fold;
          state_q <= StFold2;
        end
        StFold2: begin
          acc_q        <= fold;
          csum_q       <= final_csum;
          csum_valid_q <= 1'b1;
          state_q      <= StDone;
        end
        StDone: begin
          if (csum_ready) begin
            csum_valid_q <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign csum       = csum_q;
  assign csum_valid = csum_valid_q;
  assign byte_count = byte_count_q;
  assign err        = err_q;

endmodule

// File: tb/tb_csum_accumulator.sv
// Directed bench for csum_accumulator; a UDP_ZERO=0 twin shares all inputs.
module tb_csum_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready, in_ready0;
  logic        in_first, in_last;
  logic [2:0]  in_bytes;
  logic [15:0] seed;
  logic [15:0] csum, csum0;
  logic        csum_valid, csum_valid0;
  logic        csum_ready;
  logic [15:0] byte_count, byte_count0;
  logic        err, err0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  csum_accumulator #(.WIDTH(32), .UDP_ZERO(1'b1)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last), .in_bytes(in_bytes), .seed(seed), .csum(csum),
    .csum_valid(csum_valid), .csum_ready(csum_ready), .byte_count(byte_count), .err(err)
  );

  csum_accumulator #(.WIDTH(32), .UDP_ZERO(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
    .in_first(in_first), .in_last(in_last), .in_bytes(in_bytes), .seed(seed), .csum(csum0),
    .csum_valid(csum_valid0), .csum_ready(csum_ready), .byte_count(byte_count0), .err(err0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one beat for exactly one clock edge, then deasserts in_valid.
  task automatic beat(input logic [31:0] d, input logic f, input logic l,
                      input logic [2:0] n, input logic [15:0] s);
    in_data  = d;
    in_first = f;
    in_last  = l;
    in_bytes = n;
    seed     = s;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called just after the last beat's edge: checks latency, result, then handshakes.
  task automatic result(input string tag, input logic [15:0] exp_csum,
                        input logic [15:0] exp_bytes);
    chk({tag, "_valid_t1"}, {31'h0, csum_valid}, 32'h0);
    tick();
    chk({tag, "_valid_t2"}, {31'h0, csum_valid}, 32'h0);
    tick();
    chk({tag, "_valid_t3"}, {31'h0, csum_valid}, 32'h1);
    chk({tag, "_csum"}, {16'h0, csum}, {16'h0, exp_csum});
    chk({tag, "_bytes"}, {16'h0, byte_count}, {16'h0, exp_bytes});
    csum_ready = 1'b1;
    tick();
    csum_ready = 1'b0;
    chk({tag, "_valid_clr"}, {31'h0, csum_valid}, 32'h0);
    chk({tag, "_ready_back"}, {31'h0, in_ready}, 32'h1);
  endtask

  initial begin
    reset = 1'b1; in_data = '0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    in_bytes = '0; seed = '0; csum_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_valid", {31'h0, csum_valid}, 32'h0);
    chk("rst_csum", {16'h0, csum}, 32'h0);
    chk("rst_bytes", {16'h0, byte_count}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);

    // Single full word.
    beat(32'h45000073, 1'b1, 1'b1, 3'd4, 16'h0000);
    result("t1", 16'hBA8C, 16'd4);

    // Three valid bytes, tail padded with zero.
    beat(32'hAABBCCDD, 1'b1, 1'b1, 3'd3, 16'h0000);
    result("t2", 16'h8943, 16'd3);

    // Two folds needed; in_bytes=0 means 4.
    beat(32'hFFFFFFFF, 1'b1, 1'b0, 3'd0, 16'h0001);
    beat(32'hFFFFFFFF, 1'b0, 1'b1, 3'd0, 16'h0000);
    chk("t3_ready_fold", {31'h0, in_ready}, 32'h0);
    result("t3", 16'hFFFE, 16'd8);

    // Zero checksum: UDP rule on dut, raw zero on dut0.
    beat(32'h0000FFFF, 1'b1, 1'b1, 3'd4, 16'h0000);
    tick();
    tick();
    chk("t4_udp", {16'h0, csum}, 32'h0000FFFF);
    chk("t4_raw", {16'h0, csum0}, 32'h00000000);
    chk("t4_raw_valid", {31'h0, csum_valid0}, 32'h1);

    // Back-pressure: result stays put while csum_ready is low.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_hold_valid", {31'h0, csum_valid}, 32'h1);
      chk("t5_hold_csum", {16'h0, csum}, 32'h0000FFFF);
      chk("t5_hold_ready", {31'h0, in_ready}, 32'h0);
    end
    csum_ready = 1'b1;
    tick();
    csum_ready = 1'b0;
    chk("t5_valid_clr", {31'h0, csum_valid}, 32'h0);
    chk("t5_ready_back", {31'h0, in_ready}, 32'h1);

    // Seeded two-beat packet ending on one byte.
    beat(32'h12345678, 1'b1, 1'b0, 3'd4, 16'h0010);
    beat(32'h9ABCDEF0, 1'b0, 1'b1, 3'd1, 16'hFFFF);
    result("t7", 16'hFD42, 16'd5);

    // First beat in ACCUM restarts; only the new packet counts.
    beat(32'h11112222, 1'b1, 1'b0, 3'd4, 16'h1234);
    chk("t6_no_err", {31'h0, err}, 32'h0);
    beat(32'h00010002, 1'b1, 1'b1, 3'd4, 16'h0000);
    chk("t6_err", {31'h0, err}, 32'h1);
    result("t6", 16'hFFFC, 16'd4);
    chk("t6_err_pulse", {31'h0, err}, 32'h0);

    // Non-first beat in IDLE is dropped with an error.
    beat(32'hDEADBEEF, 1'b0, 1'b1, 3'd4, 16'h0000);
    chk("t8_err", {31'h0, err}, 32'h1);
    chk("t8_ready", {31'h0, in_ready}, 32'h1);
    beat(32'h45000073, 1'b1, 1'b1, 3'd4, 16'h0000);
    result("t8", 16'hBA8C, 16'd4);

    // Reset mid-packet clears everything; next packet is clean.
    beat(32'h12345678, 1'b1, 1'b0, 3'd4, 16'h0000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t9_ready", {31'h0, in_ready}, 32'h1);
    chk("t9_valid", {31'h0, csum_valid}, 32'h0);
    chk("t9_csum", {16'h0, csum}, 32'h0);
    chk("t9_bytes", {16'h0, byte_count}, 32'h0);
    chk("t9_err", {31'h0, err}, 32'h0);
    beat(32'h45000073, 1'b0, 1'b1, 3'd4, 16'h0000);
    chk("t9_need_first", {31'h0, err}, 32'h1);
    beat(32'hAABBCCDD, 1'b1, 1'b1, 3'd3, 16'h0000);
    result("t9", 16'h8943, 16'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
